// File: rtl/bcd_7seg_scan.sv
// Five-digit multiplexed 7-segment driver. Digits are double-buffered and only
// committed at frame wrap so a scanned frame never mixes old and new values.
module bcd_7seg_scan #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ten_thousands,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic       en,
  output logic [6:0] seg,
  output logic [4:0] an,
  output logic       frame_done
);

  localparam int             PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [4:0]     AN_OFF  = AN_ACTIVE_LOW ? 5'h1F : 5'h00;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [19:0]   shadow;
  logic [19:0]   disp;
  logic          pending;
  logic          tick;
  logic          wrap;
  logic [19:0]   din;

  assign din  = {ten_thousands, thousands, hundreds, tens, units};
  assign tick = (presc == PRE_MAX);
  assign wrap = tick && (idx == 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 3'd0;
    end else if (tick) begin
      presc <= '0;
      idx   <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A load landing on the wrap edge bypasses the shadow so it shows next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      disp       <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (load) shadow <= din;
      if (wrap) begin
        if (load)         disp <= din;
        else if (pending) disp <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
      frame_done <= wrap;
    end
  end

  // zero_above[k]: display digits k..4 are all zero
  logic [4:1] zero_above;
  always_comb begin
    zero_above    = '0;
    zero_above[4] = (disp[19:16] == 4'd0);
    zero_above[3] = zero_above[4] && (disp[15:12] == 4'd0);
    zero_above[2] = zero_above[3] && (disp[11:8] == 4'd0);
    zero_above[1] = zero_above[2] && (disp[7:4] == 4'd0);
  end

  logic [3:0] cur_digit;
  logic       cur_blank;
  logic [4:0] an_sel;
  always_comb begin
    cur_digit = disp[3:0];
    cur_blank = 1'b0;
    an_sel    = 5'b00001;
    case (idx)
      3'd1: begin cur_digit = disp[7:4];   cur_blank = zero_above[1]; an_sel = 5'b00010; end
      3'd2: begin cur_digit = disp[11:8];  cur_blank = zero_above[2]; an_sel = 5'b00100; end
      3'd3: begin cur_digit = disp[15:12]; cur_blank = zero_above[3]; an_sel = 5'b01000; end
      3'd4: begin cur_digit = disp[19:16]; cur_blank = zero_above[4]; an_sel = 5'b10000; end
      default: ;
    endcase
  end

  logic [6:0] seg_code;
  always_comb begin
    seg_code = 7'h40;
    case (cur_digit)
      4'd0: seg_code = 7'h3F;
      4'd1: seg_code = 7'h06;
      4'd2: seg_code = 7'h5B;
      4'd3: seg_code = 7'h4F;
      4'd4: seg_code = 7'h66;
      4'd5: seg_code = 7'h6D;
      4'd6: seg_code = 7'h7D;
      4'd7: seg_code = 7'h07;
      4'd8: seg_code = 7'h7F;
      4'd9: seg_code = 7'h6F;
      default: seg_code = 7'h40;
    endcase
  end

  logic       lit;
  logic [4:0] an_hi;
  logic [6:0] seg_hi;
  always_comb begin
    lit    = en && !(BLANK_LZ && cur_blank);
    an_hi  = lit ? an_sel : 5'b00000;
    seg_hi = lit ? seg_code : 7'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= an_hi ^ {5{AN_ACTIVE_LOW}};
      seg <= seg_hi ^ {7{SEG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Scoreboarded bench for bcd_7seg_scan: stimulus queues the expected scan of each
// frame, a monitor captures every slot after each frame_done and compares.
module tb_bcd_7seg_scan;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] ten_thousands, thousands, hundreds, tens, units;
  logic       en;
  logic [6:0] seg;
  logic [4:0] an;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  localparam int NF = 9;

  typedef struct packed {
    logic [24:0] an;
    logic [34:0] seg;
  } exp_t;

  typedef struct packed {
    logic        en;
    logic [1:0]  mode;   // 0 none, 1 mid-frame load, 2 two loads, 3 load in wrap cycle
    logic [19:0] d1;
    logic [19:0] d2;
    logic [24:0] an_e;   // {slot4..slot0}
    logic [34:0] seg_e;
  } vec_t;

  exp_t sb_q[$];

  bcd_7seg_scan #(
    .REFRESH_DIV(4),
    .BLANK_LZ(1'b1),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .ten_thousands(ten_thousands),
    .thousands(thousands),
    .hundreds(hundreds),
    .tens(tens),
    .units(units),
    .en(en),
    .seg(seg),
    .an(an),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic drive(input logic [19:0] d);
    {ten_thousands, thousands, hundreds, tens, units} = d;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (!frame_done) begin
      @(negedge clk);
      n++;
      if (n > 60) timeout(name);
    end
  endtask

  function automatic vec_t get_vec(input int i);
    vec_t v;
    v = '0;
    v.en = 1'b1;
    case (i)
      0: begin v.mode = 2'd1; v.d1 = 20'h12345;
         v.an_e  = {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1E};
         v.seg_e = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}; end
      1: begin v.mode = 2'd1; v.d1 = 20'h00042;
         v.an_e  = {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E};
         v.seg_e = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}; end
      2: begin v.mode = 2'd1; v.d1 = 20'h00000;
         v.an_e  = {5'h1F, 5'h1F, 5'h1F, 5'h1D, 5'h1E};
         v.seg_e = {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}; end
      3: begin v.mode = 2'd1; v.d1 = 20'hC000A;
         v.an_e  = {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1E};
         v.seg_e = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}; end
      4: begin v.mode = 2'd2; v.d1 = 20'h00001; v.d2 = 20'h00007;
         v.an_e  = {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E};
         v.seg_e = {7'h3F, 7'h40, 7'h40, 7'h40, 7'h3F}; end
      5: begin v.mode = 2'd3; v.d1 = 20'h00906;
         v.an_e  = {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1E};
         v.seg_e = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}; end
      6: begin v.mode = 2'd0;
         v.an_e  = {5'h1F, 5'h1F, 5'h1B, 5'h1D, 5'h1E};
         v.seg_e = {7'h7F, 7'h7F, 7'h10, 7'h40, 7'h02}; end
      7: begin v.en = 1'b0; v.mode = 2'd1; v.d1 = 20'h87654;
         v.an_e  = {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
         v.seg_e = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}; end
      default: begin v.mode = 2'd0;
         v.an_e  = {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E};
         v.seg_e = {7'h00, 7'h78, 7'h02, 7'h12, 7'h19}; end
    endcase
    return v;
  endfunction

  task automatic stimulus();
    vec_t v;
    exp_t e;
    for (int f = 0; f < NF; f++) begin
      wait_frame("stim frame_done");
      v = get_vec(f);
      e.an  = v.an_e;
      e.seg = v.seg_e;
      sb_q.push_back(e);
      en = v.en;
      case (v.mode)
        2'd1: begin
          repeat (7) @(negedge clk);
          drive(v.d1); load = 1'b1;
          @(negedge clk); load = 1'b0;
        end
        2'd2: begin
          repeat (3) @(negedge clk);
          drive(v.d1); load = 1'b1;
          @(negedge clk); load = 1'b0;
          repeat (5) @(negedge clk);
          drive(v.d2); load = 1'b1;
          @(negedge clk); load = 1'b0;
        end
        2'd3: begin
          repeat (19) @(negedge clk);
          drive(v.d1); load = 1'b1;
          @(negedge clk); load = 1'b0;
        end
        default: @(negedge clk);
      endcase
    end
  endtask

  task automatic monitor();
    logic [24:0] an_got;
    logic [34:0] seg_got;
    exp_t e;
    int gap;
    for (int f = 0; f < NF; f++) begin
      gap = 0;
      while (!frame_done) begin
        @(negedge clk);
        gap++;
        if (gap > 60) timeout("mon frame_done");
      end
      if (f > 0) chk($sformatf("frame_period f%0d", f), 35'(17 + gap), 35'd20);
      @(negedge clk);
      chk($sformatf("frame_done_width f%0d", f), 35'(frame_done), 35'd0);
      an_got  = '0;
      seg_got = '0;
      an_got[4:0]  = an;
      seg_got[6:0] = seg;
      for (int k = 1; k < 5; k++) begin
        repeat (4) @(negedge clk);
        an_got[k*5 +: 5]  = an;
        seg_got[k*7 +: 7] = seg;
      end
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty f%0d got 0 entries expected 1", f);
      end else begin
        e = sb_q.pop_front();
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("an f%0d slot%0d", f, k), 35'(an_got[k*5 +: 5]), 35'(e.an[k*5 +: 5]));
          chk($sformatf("seg f%0d slot%0d", f, k), 35'(seg_got[k*7 +: 7]), 35'(e.seg[k*7 +: 7]));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    en    = 1'b1;
    drive(20'h0);
    repeat (3) @(negedge clk);
    chk("reset_an", 35'(an), 35'h1F);
    chk("reset_seg", 35'(seg), 35'h7F);
    chk("reset_frame_done", 35'(frame_done), 35'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cycle1_an", 35'(an), 35'h1E);
    chk("cycle1_seg", 35'(seg), 35'h40);
    repeat (3) @(negedge clk);
    chk("cycle4_an", 35'(an), 35'h1E);
    @(negedge clk);
    chk("cycle5_an_blank", 35'(an), 35'h1F);

    fork
      stimulus();
      monitor();
    join

    // Queue a pending load, then reset mid-slot while digit 4 is lit.
    drive(20'h00321);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_reset_an_lit", 35'(an), 35'h0F);
    rst_n = 1'b0;
    #1;
    chk("async_reset_an", 35'(an), 35'h1F);
    chk("async_reset_seg", 35'(seg), 35'h7F);
    chk("async_reset_frame_done", 35'(frame_done), 35'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_an", 35'(an), 35'h1E);
    chk("post_reset_seg", 35'(seg), 35'h40);
    wait_frame("post_reset frame_done");
    @(negedge clk);
    chk("pending_discarded_an", 35'(an), 35'h1E);
    chk("pending_discarded_seg", 35'(seg), 35'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_7seg_scan.md
Name: bcd_7seg_scan

Overview:
- Time-multiplexed 5-digit 7-segment display driver, directly downstream of the 16-bit binary-to-BCD decoder in the PS2 mouse datapath.
- Accepts the decoder's five BCD digits (ten_thousands..units) on a load strobe and double-buffers them.
- Commits new values only at frame boundaries, so a displayed frame never tears.
- Scans one digit per refresh slot, with optional leading-zero blanking and an active-low/high output polarity choice.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; legal range >= 2. Prescaler width is clog2(REFRESH_DIV).
- BLANK_LZ, 1: 1 blanks leading zeros; 0 shows all digits.
- SEG_ACTIVE_LOW, 1: 1 means seg bits are driven low to light a segment.
- AN_ACTIVE_LOW, 1: 1 means an bits are driven low to select a digit.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe; capture the five digit inputs.
- ten_thousands  in  4  BCD digit 4 (most significant).
- thousands  in  4  BCD digit 3.
- hundreds  in  4  BCD digit 2.
- tens  in  4  BCD digit 1.
- units  in  4  BCD digit 0.
- en  in  1  display enable.
- seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}.
- an  out  5  digit select; an[k] selects digit k, an[0] is units.
- frame_done  out  1  one-cycle pulse on each frame wrap.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - prescaler = 0, digit index = 0.
  - shadow register = 0, display register = 0, pending = 0.
  - frame_done = 0.
  - an = all inactive, seg = all inactive.
- Prescaler: counts 0..REFRESH_DIV-1; tick = (prescaler == REFRESH_DIV-1).
- Digit index: advances on tick, 0 -> 1 -> 2 -> 3 -> 4 -> 0.
- Frame wrap: a tick while index == 4.
  - frame_done = 1 for the cycle following the wrap edge.
- Load:
  - When load = 1, shadow <= inputs and pending <= 1 at the same edge.
  - Repeated loads before a wrap overwrite the shadow; the last load wins.
- Commit at wrap:
  - If pending, display <= shadow and pending <= 0.
  - If load = 1 in the wrap cycle itself, display <= the inputs directly and pending <= 0.
- Segment encoding, active-high, before polarity is applied:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10-15 (invalid BCD) = 40 (dash).
- Leading-zero blanking (BLANK_LZ = 1): digit k (k >= 1) is blanked when display digits k..4 are all 0. Units is never blanked.
- Blanked digit: its an bit stays inactive and seg is all inactive for that slot.
- Outputs: an and seg are registered from (index, display, en), one cycle behind an index change.
  - First cycle after reset release: an selects digit 0, seg shows '0'.
- en = 0:
  - an and seg are all inactive from the next edge.
  - Prescaler, index, load and commit keep running, and frame_done keeps pulsing.
- Polarity: applied at the output registers; reset values honour the polarity parameters.
- Reset mid-frame: all state returns to reset values immediately; pending data is discarded.

Test Plan (REFRESH_DIV=4, BLANK_LZ=1, both polarities active-low):
- Reset and release:
  - During reset: an=11111, seg=7F, frame_done=0.
  - Cycle 1 after release: an=11110, seg=40.
  - Index advances every 4 cycles; frame_done pulses every 20 cycles.
- Load 1,2,3,4,5 mid-frame:
  - Current frame still shows the old data.
  - After frame_done, the next frame shows an=01111 with seg=79 ('1') through an=11110 with seg=12 ('5').
- Load 0,0,0,4,2:
  - Slots for digits 4..2 have an=11111 and seg=7F.
  - Digit 1 shows seg=19 ('4'); digit 0 shows seg=24 ('2').
  - Load all zeros: only the units slot lights, seg=40.
- Load units=A:
  - Digit 0 shows seg=3F (dash).
  - Digit 4 = C shows a dash as well, and disables blanking for the lower digits.
- Two loads in one frame, values 1 then 7 in units: next frame shows '7'.
  - Load asserted in the wrap cycle: committed the same edge, visible the following frame with no extra delay.
- en = 0: an=11111 and seg=7F within one cycle, while frame_done continues pulsing.
  - Assert rst_n = 0 asynchronously mid-slot: outputs go inactive immediately, without waiting for a clock edge.
